dbg_bus_sequencer: RTL

Debug-side bus master sequencer. It accepts word, half or byte read/write commands from the debug port front end, optionally as auto-incrementing bursts. It requests a CPU halt, waits for the halt to take effect, then drives the `dbg_*` master inputs of the bus arbiter. Each beat's read data or write acknowledgement is returned through a valid/ready response channel.

---
 rtl/dbg_bus_pkg.sv | 45 ++++
 rtl/dbg_bus_sequencer_if.sv | 40 ++++
 rtl/dbg_addr_stepper.sv | 11 +
 rtl/dbg_bus_sequencer.sv | 98 +++++++++
 4 files changed

// File: rtl/dbg_bus_pkg.sv
// dbg_bus_pkg: bus encodings, FSM states and the sequencer register bundle.
package dbg_bus_pkg;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, HALT_WAIT, ACCESS, READ_WAIT, RESPOND, RELEASE} state_t;

    typedef struct packed {
        state_t      state;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic [7:0]  remaining;
        logic        write;
        logic        keep;
        logic [15:0] cnt;
        logic [1:0]  lat;
        logic        cmd_ready;
        logic        halt_req;
        logic        rsp_valid;
        logic        rsp_error;
        logic        rsp_last;
        logic [31:0] rsp_data;
        logic [1:0]  mode;
    } seq_regs_t;

    // Error beats are always final and carry no data.
    function automatic seq_regs_t load_beat(seq_regs_t s, logic err, logic [31:0] d);
        seq_regs_t o;
        o = s;
        o.state = RESPOND;
        o.rsp_valid = 1'b1;
        o.rsp_error = err;
        o.rsp_last = err || s.remaining == 8'd0;
        o.rsp_data = err ? 32'd0 : d;
        return o;
    endfunction

endpackage

// File: rtl/dbg_bus_sequencer_if.sv
// dbg_bus_sequencer_if: command, response, halt and bus-master signals of the debug sequencer.
interface dbg_bus_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_width;
    logic [7:0]  cmd_len;
    logic        cmd_keep_halt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        rsp_last;
    logic        halt_req;
    logic        ds_cpu_halt;
    logic [31:0] dbg_address;
    logic [31:0] dbg_write_data;
    logic [1:0]  dbg_reqw;
    logic [1:0]  dbg_mode;
    logic        dbg_reqs;
    logic [31:0] dbg_read_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_data, cmd_width, cmd_len, cmd_keep_halt,
        input  rsp_ready, ds_cpu_halt, dbg_read_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_last, halt_req,
        output dbg_address, dbg_write_data, dbg_reqw, dbg_mode, dbg_reqs
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_data, cmd_width, cmd_len, cmd_keep_halt,
        output rsp_ready, ds_cpu_halt, dbg_read_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_last, halt_req,
        input  dbg_address, dbg_write_data, dbg_reqw, dbg_mode, dbg_reqs
    );

endinterface

// File: rtl/dbg_addr_stepper.sv
// dbg_addr_stepper: per-beat address increment for the access width.
module dbg_addr_stepper
    import dbg_bus_pkg::*;
(
    input  logic [1:0]  width,
    output logic [31:0] increment
);

    assign increment = width == WIDTH_BYTE ? 32'd1 : width == WIDTH_HALF ? 32'd2 : 32'd4;

endmodule

// File: rtl/dbg_bus_sequencer.sv
// dbg_bus_sequencer: halts the CPU, then runs debug read/write bursts on the arbiter's dbg master port.
module dbg_bus_sequencer
    import dbg_bus_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    dbg_bus_sequencer_if.master bus
);

    seq_regs_t   r;
    seq_regs_t   n;
    logic [31:0] step;

    dbg_addr_stepper u_stepper (
        .width     (r.width),
        .increment (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
            r.cmd_ready <= 1'b1;
        end else begin
            r <= n;
        end
    end

    always_comb begin
        n = r;
        unique case (r.state)
            IDLE: if (bus.cmd_valid) begin
                n.addr = bus.cmd_address;
                n.data = bus.cmd_data;
                n.width = bus.cmd_width;
                n.remaining = bus.cmd_len;
                n.write = bus.cmd_write;
                n.keep = bus.cmd_keep_halt;
                n.halt_req = 1'b1;
                n.cnt = '0;
                n.state = bus.ds_cpu_halt ? ACCESS : HALT_WAIT;
            end
            HALT_WAIT: begin
                n.cnt = &r.cnt ? r.cnt : r.cnt + 16'd1;
                if (bus.ds_cpu_halt) n.state = ACCESS;
                else if ({1'b0, r.cnt} + 17'd1 >= 17'(HALT_TIMEOUT)) n = load_beat(n, 1'b1, '0);
            end
            ACCESS: begin
                n.lat = '0;
                if (!bus.ds_cpu_halt) n = load_beat(n, 1'b1, '0);
                else if (r.write || READ_LATENCY == 0) n = load_beat(n, 1'b0, r.write ? '0 : bus.dbg_read_data);
                else n.state = READ_WAIT;
            end
            READ_WAIT: begin
                if (!bus.ds_cpu_halt) n = load_beat(n, 1'b1, '0);
                else if (r.lat == 2'(READ_LATENCY - 1)) n = load_beat(n, 1'b0, bus.dbg_read_data);
                else n.lat = r.lat + 2'd1;
            end
            RESPOND: begin
                if (bus.rsp_ready) begin
                    n.rsp_valid = 1'b0;
                    n.rsp_error = 1'b0;
                    n.rsp_last = 1'b0;
                    n.rsp_data = '0;
                    if (r.rsp_error || r.remaining == 8'd0) begin
                        n.state = r.keep && !r.rsp_error ? IDLE : RELEASE;
                    end else begin
                        n.state = ACCESS;
                        n.remaining = r.remaining - 8'd1;
                        n.addr = r.addr + step;
                    end
                end else if (!bus.ds_cpu_halt && !r.rsp_error) begin
                    n = load_beat(n, 1'b1, '0);
                end
            end
            RELEASE: if (!bus.ds_cpu_halt) n.state = IDLE;
            default: n.state = IDLE;
        endcase
        if (n.state == RELEASE) n.halt_req = 1'b0;
        n.cmd_ready = n.state == IDLE;
        n.mode = n.state == ACCESS || n.state == READ_WAIT ? (n.write ? MODE_WRITE : MODE_READ) : MODE_NONE;
    end

    assign bus.cmd_ready = r.cmd_ready;
    assign bus.rsp_valid = r.rsp_valid;
    assign bus.rsp_data = r.rsp_data;
    assign bus.rsp_error = r.rsp_error;
    assign bus.rsp_last = r.rsp_last;
    assign bus.halt_req = r.halt_req;
    assign bus.dbg_address = r.addr;
    assign bus.dbg_write_data = r.data;
    assign bus.dbg_reqw = r.width;
    assign bus.dbg_mode = r.mode;
    assign bus.dbg_reqs = 1'b0;

endmodule
